mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit sitting directly upstream of mips_alu.
- Accepts one 32-bit instruction per valid/ready handshake and decodes it into the ALU's 4-bit ALUOp code and operand selects.
- Sequences the instruction through DECODE/EXEC/MEM/WB states, consuming the ALU's signal_zero to resolve branches.
- Drives register-file write, data-memory request and PC-update controls for the datapath.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in MEM waiting for mem_ack before aborting with bus_error (legal range 1..255).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- instr  input  32  instruction word, sampled at handshake.
- instr_valid  input  1  upstream has an instruction.
- instr_ready  output  1  controller can accept; high only in IDLE.
- signal_zero  input  1  ALU branch flag (1 = branch condition true for both the beq and bne codes).
- mem_ack  input  1  data memory completed the request.
- alu_op  output  4  ALUOp code: jr=0 add=1 and=2 nor=3 or=4 slt=5 sll=6 srl=7 subu=8 sub=9 sltu=10 addu=11 beq=12 bne=13.
- alu_src_a  output  1  0=rs, 1=rt (shifts).
- alu_src_b  output  2  0=rt, 1=sign-ext imm, 2=zero-ext imm, 3=zero-ext shamt.
- rs_addr, rt_addr  output  5 each  latched instr[25:21], instr[20:16].
- wr_addr  output  5  rd for R-type, rt for I-type/lw.
- imm  output  16  latched instr[15:0].
- reg_we  output  1  register write strobe.
- mem_to_reg  output  1  write-back source is memory.
- mem_req  output  1  data-memory request.
- mem_we  output  1  request is a store.
- pc_we  output  1  PC update strobe.
- pc_sel  output  2  0=pc+4, 1=branch target, 2=jump target, 3=rs (jr).
- done  output  1  one-cycle retire pulse.
- illegal  output  1  one-cycle illegal-instruction pulse.
- bus_error  output  1  one-cycle memory-timeout pulse.

Behaviour:
- Reset: asynchronous; on assertion all outputs go to 0 immediately except instr_ready=1, state=IDLE, timeout counter=0. Reset mid-operation aborts the instruction: no reg_we, pc_we or mem_req is issued afterwards.
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch instr and go to DECODE.
  - instr_valid while not in IDLE is ignored; the upstream holds the instruction.
- DECODE (1 cycle):
  - Register alu_op, selects, wr_addr and the instruction class.
  - Unsupported opcode/funct: illegal=1 for this cycle, return to IDLE, no other strobes.
- Decode table:
  - R-type (op 0) funct:
    - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu: src_a=0, src_b=0.
    - 0x24 and, 0x25 or, 0x27 nor: src_a=0, src_b=0.
    - 0x2A slt, 0x2B sltu: src_a=0, src_b=0.
    - 0x00 sll, 0x02 srl: src_a=1, src_b=3.
    - 0x08 jr: alu_op=0, pc_sel=3, no write.
  - I-type opcode:
    - 0x08 addi→add, 0x09 addiu→addu: src_b=1.
    - 0x0A slti→slt, 0x0B sltiu→sltu: src_b=1.
    - 0x0C andi→and, 0x0D ori→or: src_b=2.
    - 0x23 lw→add: src_b=1, mem_to_reg=1.
    - 0x2B sw→add: src_b=1, mem_we=1.
    - 0x04 beq→12, 0x05 bne→13: src_b=0.
    - 0x02 j: pc_sel=2.
- EXEC (1 cycle):
  - alu_op and selects stable for the whole cycle.
  - Branches: signal_zero is sampled at the end of EXEC; pc_sel=1 if 1, else 0.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - mem_req=1 (mem_we for sw) held until mem_ack.
  - mem_ack sampled high → WB.
  - Counter increments each MEM cycle. If MEM_TIMEOUT cycles elapse with no ack: bus_error=1 for one cycle, mem_req drops, return to IDLE, no write-back or pc_we.
  - mem_ack in the same cycle the timeout expires counts as ack (ack wins).
- WB (1 cycle):
  - pc_we=1, done=1.
  - reg_we=1 for R-type ALU ops, I-type ALU ops and lw. Not for sw, branches, j or jr.
  - Next state IDLE; instr_ready returns in the following cycle.
- Latency (acceptance edge = cycle 0):
  - Non-memory instruction: done in cycle 3; next acceptance possible at the end of cycle 4.
  - Memory instruction: 4 + (cycles waiting for ack).
- alu_op and all selects hold their value from DECODE until the next acceptance.

Test Plan:
- Reset: hold reset_n=0 mid-MEM of a lw → mem_req falls asynchronously, instr_ready=1. After release, no reg_we or pc_we seen.
- add $3,$1,$2 (0x00221820):
  - DECODE/EXEC: alu_op=1, src_a=0, src_b=0.
  - WB (cycle 3): reg_we=1, wr_addr=3, pc_sel=0, done=1.
- sll $2,$3,4 (0x00031100): alu_op=6, src_a=1, src_b=3, wr_addr=2, reg_we in WB.
- beq $1,$2,3 (0x10220003):
  - With signal_zero=1 in EXEC: WB pc_sel=1, pc_we=1, reg_we=0.
  - Repeat with signal_zero=0: pc_sel=0.
- lw $5,4($1) (0x8C250004), mem_ack after 3 MEM cycles: mem_req high exactly 3 cycles, mem_we=0, alu_op=1, src_b=1. WB: reg_we=1, mem_to_reg=1, wr_addr=5.
- Timeout and illegal:
  - sw (0xAC250004) with no ack: bus_error pulse after 15 MEM cycles, no pc_we.
  - 0xFC000000: illegal pulse in DECODE, back in IDLE next cycle.

Source files
------------

// File: rtl/mips_mc_ctrl_if.sv
// Handshake and datapath-control bundle between mips_mc_ctrl and its neighbours.
// master = the controller, slave = upstream fetch plus ALU/memory datapath.
interface mips_mc_ctrl_if;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        signal_zero;
   logic        mem_ack;
   logic [3:0]  alu_op;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [4:0]  wr_addr;
   logic [15:0] imm;
   logic        reg_we;
   logic        mem_to_reg;
   logic        mem_req;
   logic        mem_we;
   logic        pc_we;
   logic [1:0]  pc_sel;
   logic        done;
   logic        illegal;
   logic        bus_error;

   modport master (
      input  instr, instr_valid, signal_zero, mem_ack,
      output instr_ready, alu_op, alu_src_a, alu_src_b, rs_addr, rt_addr, wr_addr, imm,
             reg_we, mem_to_reg, mem_req, mem_we, pc_we, pc_sel, done, illegal, bus_error
   );

   modport slave (
      output instr, instr_valid, signal_zero, mem_ack,
      input  instr_ready, alu_op, alu_src_a, alu_src_b, rs_addr, rt_addr, wr_addr, imm,
             reg_we, mem_to_reg, mem_req, mem_we, pc_we, pc_sel, done, illegal, bus_error
   );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: IDLE/DECODE/EXEC/MEM/WB sequencing in front of mips_alu.
// All outputs are registered; decoding is done on the accepted word so DECODE already shows it.
module mips_mc_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           reset_n,
   mips_mc_ctrl_if.master bus
);

   localparam logic [3:0] OP_JR   = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_NOR  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SUBU = 4'd8;
   localparam logic [3:0] OP_SUB  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_ADDU = 4'd11;
   localparam logic [3:0] OP_BEQ  = 4'd12;
   localparam logic [3:0] OP_BNE  = 4'd13;

   localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
   typedef enum logic [2:0] {CLS_ALU, CLS_LW, CLS_SW, CLS_BR, CLS_JMP} cls_t;

   state_t      state_reg;
   cls_t        cls_reg;
   logic [7:0]  cnt_reg;
   logic        instr_ready_reg;
   logic [3:0]  alu_op_reg;
   logic        src_a_reg;
   logic [1:0]  src_b_reg;
   logic [4:0]  rs_reg;
   logic [4:0]  rt_reg;
   logic [4:0]  wr_reg;
   logic [15:0] imm_reg;
   logic        reg_we_reg;
   logic        m2r_reg;
   logic        mem_req_reg;
   logic        mem_we_reg;
   logic        pc_we_reg;
   logic [1:0]  pc_sel_reg;
   logic        done_reg;
   logic        illegal_reg;
   logic        bus_error_reg;

   logic        dec_ok;
   logic [3:0]  dec_op;
   logic        dec_a;
   logic [1:0]  dec_b;
   logic [4:0]  dec_wr;
   logic        dec_m2r;
   logic [1:0]  dec_pc_sel;
   cls_t        dec_cls;

   logic [5:0]  opcode;
   logic [5:0]  funct;

   assign opcode = bus.instr[31:26];
   assign funct  = bus.instr[5:0];

   always_comb begin
      dec_ok     = 1'b1;
      dec_op     = OP_ADD;
      dec_a      = 1'b0;
      dec_b      = 2'd0;
      dec_wr     = bus.instr[20:16];
      dec_m2r    = 1'b0;
      dec_pc_sel = 2'd0;
      dec_cls    = CLS_ALU;
      case (opcode)
         6'h00: begin
            dec_wr = bus.instr[15:11];
            case (funct)
               6'h20: dec_op = OP_ADD;
               6'h21: dec_op = OP_ADDU;
               6'h22: dec_op = OP_SUB;
               6'h23: dec_op = OP_SUBU;
               6'h24: dec_op = OP_AND;
               6'h25: dec_op = OP_OR;
               6'h27: dec_op = OP_NOR;
               6'h2A: dec_op = OP_SLT;
               6'h2B: dec_op = OP_SLTU;
               6'h00: begin
                  dec_op = OP_SLL;
                  dec_a  = 1'b1;
                  dec_b  = 2'd3;
               end
               6'h02: begin
                  dec_op = OP_SRL;
                  dec_a  = 1'b1;
                  dec_b  = 2'd3;
               end
               6'h08: begin
                  dec_op     = OP_JR;
                  dec_pc_sel = 2'd3;
                  dec_cls    = CLS_JMP;
               end
               default: dec_ok = 1'b0;
            endcase
         end
         6'h08: begin dec_op = OP_ADD;  dec_b = 2'd1; end
         6'h09: begin dec_op = OP_ADDU; dec_b = 2'd1; end
         6'h0A: begin dec_op = OP_SLT;  dec_b = 2'd1; end
         6'h0B: begin dec_op = OP_SLTU; dec_b = 2'd1; end
         6'h0C: begin dec_op = OP_AND;  dec_b = 2'd2; end
         6'h0D: begin dec_op = OP_OR;   dec_b = 2'd2; end
         6'h23: begin
            dec_op  = OP_ADD;
            dec_b   = 2'd1;
            dec_m2r = 1'b1;
            dec_cls = CLS_LW;
         end
         6'h2B: begin
            dec_op  = OP_ADD;
            dec_b   = 2'd1;
            dec_cls = CLS_SW;
         end
         6'h04: begin dec_op = OP_BEQ; dec_cls = CLS_BR; end
         6'h05: begin dec_op = OP_BNE; dec_cls = CLS_BR; end
         6'h02: begin
            dec_op     = OP_JR;
            dec_pc_sel = 2'd2;
            dec_cls    = CLS_JMP;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= S_IDLE;
         cls_reg         <= CLS_ALU;
         cnt_reg         <= 8'd0;
         instr_ready_reg <= 1'b1;
         alu_op_reg      <= 4'd0;
         src_a_reg       <= 1'b0;
         src_b_reg       <= 2'd0;
         rs_reg          <= 5'd0;
         rt_reg          <= 5'd0;
         wr_reg          <= 5'd0;
         imm_reg         <= 16'd0;
         reg_we_reg      <= 1'b0;
         m2r_reg         <= 1'b0;
         mem_req_reg     <= 1'b0;
         mem_we_reg      <= 1'b0;
         pc_we_reg       <= 1'b0;
         pc_sel_reg      <= 2'd0;
         done_reg        <= 1'b0;
         illegal_reg     <= 1'b0;
         bus_error_reg   <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted by a transition below.
         reg_we_reg    <= 1'b0;
         pc_we_reg     <= 1'b0;
         done_reg      <= 1'b0;
         illegal_reg   <= 1'b0;
         bus_error_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  state_reg       <= S_DECODE;
                  instr_ready_reg <= 1'b0;
                  rs_reg          <= bus.instr[25:21];
                  rt_reg          <= bus.instr[20:16];
                  imm_reg         <= bus.instr[15:0];
                  alu_op_reg      <= dec_op;
                  src_a_reg       <= dec_a;
                  src_b_reg       <= dec_b;
                  wr_reg          <= dec_wr;
                  m2r_reg         <= dec_m2r;
                  pc_sel_reg      <= dec_pc_sel;
                  cls_reg         <= dec_cls;
                  illegal_reg     <= ~dec_ok;
               end
            end
            S_DECODE: begin
               if (illegal_reg) begin
                  state_reg       <= S_IDLE;
                  instr_ready_reg <= 1'b1;
               end else begin
                  state_reg <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cls_reg == CLS_BR) begin
                  pc_sel_reg <= bus.signal_zero ? 2'd1 : 2'd0;
               end
               if (cls_reg == CLS_LW || cls_reg == CLS_SW) begin
                  state_reg   <= S_MEM;
                  mem_req_reg <= 1'b1;
                  mem_we_reg  <= (cls_reg == CLS_SW);
                  cnt_reg     <= 8'd0;
               end else begin
                  state_reg  <= S_WB;
                  pc_we_reg  <= 1'b1;
                  done_reg   <= 1'b1;
                  reg_we_reg <= (cls_reg == CLS_ALU);
               end
            end
            S_MEM: begin
               // An ack on the expiring cycle still completes the access.
               if (bus.mem_ack) begin
                  state_reg   <= S_WB;
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  cnt_reg     <= 8'd0;
                  pc_we_reg   <= 1'b1;
                  done_reg    <= 1'b1;
                  reg_we_reg  <= (cls_reg == CLS_LW);
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg       <= S_IDLE;
                  instr_ready_reg <= 1'b1;
                  mem_req_reg     <= 1'b0;
                  mem_we_reg      <= 1'b0;
                  cnt_reg         <= 8'd0;
                  bus_error_reg   <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            S_WB: begin
               state_reg       <= S_IDLE;
               instr_ready_reg <= 1'b1;
            end
            default: begin
               state_reg       <= S_IDLE;
               instr_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign bus.instr_ready = instr_ready_reg;
   assign bus.alu_op      = alu_op_reg;
   assign bus.alu_src_a   = src_a_reg;
   assign bus.alu_src_b   = src_b_reg;
   assign bus.rs_addr     = rs_reg;
   assign bus.rt_addr     = rt_reg;
   assign bus.wr_addr     = wr_reg;
   assign bus.imm         = imm_reg;
   assign bus.reg_we      = reg_we_reg;
   assign bus.mem_to_reg  = m2r_reg;
   assign bus.mem_req     = mem_req_reg;
   assign bus.mem_we      = mem_we_reg;
   assign bus.pc_we       = pc_we_reg;
   assign bus.pc_sel      = pc_sel_reg;
   assign bus.done        = done_reg;
   assign bus.illegal     = illegal_reg;
   assign bus.bus_error   = bus_error_reg;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed cases plus random instructions
// compared against a table-driven transaction-level reference.
module tb_mips_mc_ctrl;

   localparam int TO = 15;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mips_mc_ctrl_if bus();

   mips_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference tables: funct -> ALUOp, opcode -> ALUOp, opcode -> operand-B select.
   int r_op[int];
   int i_op[int];
   int i_srcb[int];

   int r_list[12] = '{32, 33, 34, 35, 36, 37, 39, 42, 43, 0, 2, 8};
   int i_list[11] = '{8, 9, 10, 11, 12, 13, 35, 43, 4, 5, 2};

   typedef struct {
      bit legal;
      int op;
      int a;
      int b;
      bit wr_en;
      int wr;
      bit lw;
      bit sw;
      int kind;   // 0 plain, 1 branch, 2 j, 3 jr
   } ref_t;

   function automatic ref_t ref_model(input logic [31:0] ins);
      ref_t r;
      int   op;
      int   fn;
      op = int'(ins[31:26]);
      fn = int'(ins[5:0]);
      r.legal = 0; r.op = 0; r.a = 0; r.b = 0; r.wr_en = 0; r.wr = 0;
      r.lw = 0; r.sw = 0; r.kind = 0;
      if (op == 0) begin
         if (r_op.exists(fn)) begin
            r.legal = 1;
            r.op    = r_op[fn];
            r.wr    = int'(ins[15:11]);
            r.wr_en = (fn != 8);
            if (fn == 0 || fn == 2) begin r.a = 1; r.b = 3; end
            if (fn == 8) r.kind = 3;
         end
      end else if (i_op.exists(op)) begin
         r.legal = 1;
         r.op    = i_op[op];
         r.b     = i_srcb[op];
         r.wr    = int'(ins[20:16]);
         r.lw    = (op == 35);
         r.sw    = (op == 43);
         r.wr_en = !(op == 4 || op == 5 || op == 2 || op == 43);
         r.kind  = (op == 4 || op == 5) ? 1 : (op == 2) ? 2 : 0;
      end
      return r;
   endfunction

   task automatic run_instr(input logic [31:0] ins, input bit sz, input int k);
      ref_t e;
      int cyc, mem_cyc, memwe_n, pcwe_n, regwe_n, wait_n;
      int done_c, ill_c, berr_c, exp_pcsel;
      logic [1:0] pcsel_at;
      logic [4:0] wr_at;
      logic m2r_at;
      logic [3:0] op_end;
      bit term;
      e = ref_model(ins);
      cyc = 0; mem_cyc = 0; memwe_n = 0; pcwe_n = 0; regwe_n = 0; wait_n = 0;
      done_c = -1; ill_c = -1; berr_c = -1;
      pcsel_at = 2'd0; wr_at = 5'd0; m2r_at = 1'b0; op_end = 4'd0; term = 0;
      while (!bus.instr_ready && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      chk("ready_before", 32'(bus.instr_ready), 32'd1);
      bus.instr = ins;
      bus.instr_valid = 1'b1;
      bus.signal_zero = sz;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      cyc = 1;
      bus.instr_valid = 1'b0;
      chk("illegal_decode", 32'(bus.illegal), 32'(!e.legal));
      if (e.legal) begin
         chk("alu_op_decode", 32'(bus.alu_op), 32'(e.op));
         chk("src_a", 32'(bus.alu_src_a), 32'(e.a));
         chk("src_b", 32'(bus.alu_src_b), 32'(e.b));
         chk("rs_addr", 32'(bus.rs_addr), 32'(ins[25:21]));
         chk("rt_addr", 32'(bus.rt_addr), 32'(ins[20:16]));
         chk("imm", 32'(bus.imm), 32'(ins[15:0]));
      end
      while (!term && cyc < 300) begin
         if (cyc == 2 && e.legal) chk("alu_op_exec", 32'(bus.alu_op), 32'(e.op));
         if (bus.pc_we) pcwe_n++;
         if (bus.reg_we) regwe_n++;
         if (bus.mem_req) begin
            mem_cyc++;
            if (bus.mem_we) memwe_n++;
            bus.mem_ack = (mem_cyc == k);
         end else begin
            bus.mem_ack = 1'b0;
         end
         if (bus.done) begin
            done_c = cyc; pcsel_at = bus.pc_sel; wr_at = bus.wr_addr;
            m2r_at = bus.mem_to_reg; op_end = bus.alu_op; term = 1;
         end
         if (bus.illegal && cyc > 1) term = 1;
         if (bus.illegal && cyc == 1) begin ill_c = 1; term = 1; end
         if (bus.bus_error) begin berr_c = cyc; term = 1; end
         if (!term) begin
            @(negedge clk);
            cyc++;
         end
      end
      chk("terminated", 32'(term), 32'd1);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("ready_after", 32'(bus.instr_ready), 32'd1);
      chk("quiet_after", 32'({bus.pc_we, bus.reg_we, bus.mem_req}), 32'd0);
      if (!e.legal) begin
         chk("ill_cycle", 32'(ill_c), 32'd1);
         chk("ill_no_pcwe", 32'(pcwe_n), 32'd0);
         chk("ill_no_regwe", 32'(regwe_n), 32'd0);
      end else if ((e.lw || e.sw) && (k < 1 || k > TO)) begin
         chk("berr_cycle", 32'(berr_c), 32'(3 + TO));
         chk("to_mem_cycles", 32'(mem_cyc), 32'(TO));
         chk("to_no_pcwe", 32'(pcwe_n), 32'd0);
         chk("to_no_regwe", 32'(regwe_n), 32'd0);
         chk("to_no_done", 32'(done_c), 32'hFFFF_FFFF);
      end else begin
         exp_pcsel = (e.kind == 1) ? int'(sz) : (e.kind == 2) ? 2 : (e.kind == 3) ? 3 : 0;
         chk("done_cycle", 32'(done_c), 32'((e.lw || e.sw) ? 3 + k : 3));
         chk("pcwe_count", 32'(pcwe_n), 32'd1);
         chk("regwe_count", 32'(regwe_n), 32'(e.wr_en));
         chk("pc_sel", 32'(pcsel_at), 32'(exp_pcsel));
         chk("mem_to_reg", 32'(m2r_at), 32'(e.lw));
         chk("mem_cycles", 32'(mem_cyc), 32'((e.lw || e.sw) ? k : 0));
         chk("mem_we_cycles", 32'(memwe_n), 32'(e.sw ? k : 0));
         chk("alu_op_held", 32'(op_end), 32'(e.op));
         if (e.wr_en) chk("wr_addr", 32'(wr_at), 32'(e.wr));
      end
      $display("txn instr=%08h sz=%0d k=%0d done_c=%0d ill_c=%0d berr_c=%0d mem_cyc=%0d",
               ins, sz, k, done_c, ill_c, berr_c, mem_cyc);
   endtask

   task automatic reset_mid_mem();
      int n;
      int strobes;
      n = 0;
      strobes = 0;
      bus.instr = 32'h8C25_0004;
      bus.instr_valid = 1'b1;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      while (!bus.mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reached_mem", 32'(bus.mem_req), 32'd1);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_memreq_async", 32'(bus.mem_req), 32'd0);
      chk("rst_ready_async", 32'(bus.instr_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.pc_we || bus.reg_we || bus.mem_req) strobes++;
      end
      chk("rst_no_strobes", 32'(strobes), 32'd0);
      $display("txn reset-mid-mem lw strobes_after=%0d", strobes);
   endtask

   initial begin
      logic [31:0] ins;
      int pick;
      r_op[32] = 1;  r_op[33] = 11; r_op[34] = 9; r_op[35] = 8;
      r_op[36] = 2;  r_op[37] = 4;  r_op[39] = 3; r_op[42] = 5;
      r_op[43] = 10; r_op[0] = 6;   r_op[2] = 7;  r_op[8] = 0;
      i_op[8] = 1;  i_op[9] = 11; i_op[10] = 5; i_op[11] = 10; i_op[12] = 2;
      i_op[13] = 4; i_op[35] = 1; i_op[43] = 1; i_op[4] = 12;  i_op[5] = 13; i_op[2] = 0;
      i_srcb[8] = 1; i_srcb[9] = 1; i_srcb[10] = 1; i_srcb[11] = 1; i_srcb[35] = 1;
      i_srcb[43] = 1; i_srcb[12] = 2; i_srcb[13] = 2; i_srcb[4] = 0; i_srcb[5] = 0; i_srcb[2] = 0;

      bus.instr = 32'd0;
      bus.instr_valid = 1'b0;
      bus.signal_zero = 1'b0;
      bus.mem_ack = 1'b0;
      #12;
      chk("reset_ready", 32'(bus.instr_ready), 32'd1);
      chk("reset_alu_op", 32'(bus.alu_op), 32'd0);
      chk("reset_strobes", 32'({bus.reg_we, bus.pc_we, bus.mem_req, bus.mem_we, bus.done,
                                bus.illegal, bus.bus_error}), 32'd0);
      chk("reset_sel", 32'({bus.pc_sel, bus.alu_src_b, bus.alu_src_a, bus.mem_to_reg}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      run_instr(32'h0022_1820, 1'b0, 0);   // add $3,$1,$2
      run_instr(32'h0003_1100, 1'b1, 0);   // sll $2,$3,4
      run_instr(32'h1022_0003, 1'b1, 0);   // beq taken
      run_instr(32'h1022_0003, 1'b0, 0);   // beq not taken
      run_instr(32'h8C25_0004, 1'b0, 3);   // lw, ack after 3 MEM cycles
      run_instr(32'hAC25_0004, 1'b0, 0);   // sw, never acked
      run_instr(32'hFC00_0000, 1'b0, 0);   // illegal opcode
      run_instr(32'h8C25_0004, 1'b0, TO);  // ack on the expiring cycle
      run_instr(32'hAC25_0004, 1'b0, 1);   // sw, immediate ack
      run_instr(32'h03E0_0008, 1'b0, 0);   // jr $31
      run_instr(32'h0800_0010, 1'b0, 0);   // j
      run_instr(32'h1422_0003, 1'b1, 0);   // bne taken
      reset_mid_mem();

      for (int t = 0; t < 60; t++) begin
         pick = int'($urandom_range(0, 9));
         ins = $urandom;
         if (pick < 4) begin
            ins[31:26] = 6'd0;
            if ($urandom_range(0, 4) == 0) ins[5:0] = 6'($urandom_range(0, 63));
            else ins[5:0] = 6'(r_list[$urandom_range(0, 11)]);
         end else if (pick < 9) begin
            ins[31:26] = 6'(i_list[$urandom_range(0, 10)]);
         end
         run_instr(ins, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
